axi_sim_mem: RTL and testbench

Parametrised AXI4 slave memory model for simulation benches. It replaces the AXI-to-app-interface bridge plus behavioural DDR pair with a single block. The block adds these capabilities:
- configurable data width, depth and read latency;
- INCR, FIXED and WRAP bursts;
- byte strobes;
- protocol-error responses.

It sits directly behind the accelerator's AXI master port in every top-level testbench.

---
 rtl/axi_sim_mem_pkg.sv | 33 +++
 rtl/axi_burst_next_addr.sv | 51 +++++
 rtl/axi_sim_mem.sv | 256 +++++++++++++++++++++++++
 tb/tb_axi_sim_mem.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sim_mem_pkg.sv
// axi_sim_mem_pkg
// Shared definitions for the AXI4 simulation memory:
//   - AXI burst encodings (FIXED / INCR / WRAP / reserved)
//   - AXI response encodings (OKAY / SLVERR)
//   - write and read channel FSM state enums
//   - wrap_len_ok(): legal WRAP burst lengths (2, 4, 8 or 16 beats)
package axi_sim_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } write_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } read_state_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_next_addr.sv
// axi_burst_next_addr
// Combinational next-beat address for one AXI burst, plus the protocol
// error flag for that burst's attributes.
// Ports:
//   addr      in   current beat byte address
//   len       in   AXI len (beats - 1)
//   size      in   AXI size; anything but full bus width is an error
//   burst     in   AXI burst type
//   next_addr out  address of the following beat
//   err       out  size mismatch, reserved burst, or WRAP with illegal len
// Reserved bursts and illegal WRAP lengths advance as INCR. The step is
// always the full bus width, regardless of size.
module axi_burst_next_addr
  import axi_sim_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  err
);

  localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  logic                  wrap_ok;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] len_ext;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    wrap_ok   = (burst == BURST_WRAP) && wrap_len_ok(len);
    incr_addr = addr + STEP;
    len_ext   = {{(ADDR_WIDTH-8){1'b0}}, len};
    // Wrap window is (len+1) beats of full bus width.
    wrap_mask = ((len_ext + ADDR_WIDTH'(1)) << SIZE_LOG2) - ADDR_WIDTH'(1);
    err       = (size != 3'(SIZE_LOG2)) || (burst == BURST_RSVD) ||
                ((burst == BURST_WRAP) && !wrap_len_ok(len));
    next_addr = incr_addr;
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if (wrap_ok) begin
      next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end
  end

endmodule

// File: rtl/axi_sim_mem.sv
// axi_sim_mem
// AXI4 slave memory model: one outstanding write and one outstanding read,
// running concurrently, with INCR/FIXED/WRAP bursts, byte strobes, a
// configurable read latency and SLVERR on protocol errors.
// Ports:
//   clk, aresetn             clock, asynchronous active-low reset
//   init_calib_complete      high INIT_CYCLES cycles after reset release
//   aw*/w*/b*                AXI write address / data / response channels
//   ar*/r*                   AXI read address / data channels
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. Once this block raises a valid, it holds the valid and its
// payload unchanged until the matching ready is seen; its readies never
// depend combinationally on the master's valids.
// Memory contents survive reset. Read beats are fetched into a register one
// cycle ahead; a write landing in the fetch cycle is forwarded so the next
// beat sees it, while the beat already on the bus keeps pre-write data.
module axi_sim_mem
  import axi_sim_mem_pkg::*;
#(
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 512,
  parameter int DEPTH_LOG2  = 16,
  parameter int RD_LATENCY  = 4,
  parameter int INIT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    aresetn,
  output logic                    init_calib_complete,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int SIZE_LOG2 = $clog2(BYTES);
  localparam int WORDS     = 1 << DEPTH_LOG2;
  localparam logic [7:0] LAT_LAST = (RD_LATENCY > 0) ? 8'(RD_LATENCY - 1) : 8'd0;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // ---------------- init counter ----------------
  logic [31:0] init_cnt;
  logic        init_done;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else if (!init_done) begin
      init_cnt <= init_cnt + 32'd1;
      if (init_cnt == 32'(INIT_CYCLES - 1)) init_done <= 1'b1;
    end
  end

  assign init_calib_complete = init_done;

  // ---------------- write channel ----------------
  write_state_t          w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_next;
  logic [7:0]            w_len;
  logic [7:0]            w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_proto_err;
  logic                  w_last_err;
  logic                  w_fire;
  logic                  w_final;
  logic [DEPTH_LOG2-1:0] w_idx;

  axi_burst_next_addr #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wr_next (
    .addr      (w_addr),
    .len       (w_len),
    .size      (w_size),
    .burst     (w_burst),
    .next_addr (w_next),
    .err       (w_proto_err)
  );

  assign awready = (w_state == W_IDLE) && init_done;
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);
  assign bid     = w_id;
  assign bresp   = (bvalid && (w_proto_err || w_last_err)) ? RESP_SLVERR : RESP_OKAY;
  assign w_fire  = wvalid && wready;
  assign w_final = (w_cnt == w_len);
  assign w_idx   = w_addr[SIZE_LOG2 +: DEPTH_LOG2];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      w_state    <= W_IDLE;
      w_id       <= '0;
      w_addr     <= '0;
      w_len      <= '0;
      w_cnt      <= '0;
      w_size     <= '0;
      w_burst    <= '0;
      w_last_err <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid && awready) begin
          w_id       <= awid;
          w_addr     <= awaddr;
          w_len      <= awlen;
          w_size     <= awsize;
          w_burst    <= awburst;
          w_cnt      <= '0;
          w_last_err <= 1'b0;
          w_state    <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          w_addr <= w_next;
          w_cnt  <= w_cnt + 8'd1;
          if (wlast != w_final) w_last_err <= 1'b1;
          if (w_final) w_state <= W_RESP;
        end
        W_RESP: if (bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  read_state_t           r_state;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_next;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [7:0]            lat_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_proto_err;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  axi_burst_next_addr #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rd_next (
    .addr      (r_addr),
    .len       (r_len),
    .size      (r_size),
    .burst     (r_burst),
    .next_addr (r_next),
    .err       (r_proto_err)
  );

  // Word to be loaded into rdata at the coming edge: the first beat comes
  // from the request address, later beats from the advanced address.
  always_comb begin
    case (r_state)
      R_IDLE:  rd_idx = araddr[SIZE_LOG2 +: DEPTH_LOG2];
      R_WAIT:  rd_idx = r_addr[SIZE_LOG2 +: DEPTH_LOG2];
      default: rd_idx = r_next[SIZE_LOG2 +: DEPTH_LOG2];
    endcase
    rd_word = mem[rd_idx];
    if (w_fire && (w_idx == rd_idx)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) rd_word[b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  end

  assign arready = (r_state == R_IDLE) && init_done;
  assign rvalid  = (r_state == R_DATA);
  assign rlast   = rvalid && (r_cnt == r_len);
  assign rresp   = (rvalid && r_proto_err) ? RESP_SLVERR : RESP_OKAY;
  assign rid     = r_id;
  assign rdata   = rdata_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      lat_cnt <= '0;
      r_size  <= '0;
      r_burst <= '0;
      rdata_q <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid && arready) begin
          r_id    <= arid;
          r_addr  <= araddr;
          r_len   <= arlen;
          r_size  <= arsize;
          r_burst <= arburst;
          r_cnt   <= '0;
          lat_cnt <= '0;
          if (RD_LATENCY == 0) begin
            rdata_q <= rd_word;
            r_state <= R_DATA;
          end else begin
            r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            rdata_q <= rd_word;
            r_state <= R_DATA;
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
          end
        end
        R_DATA: if (rready) begin
          if (r_cnt == r_len) begin
            r_state <= R_IDLE;
          end else begin
            r_addr  <= r_next;
            r_cnt   <= r_cnt + 8'd1;
            rdata_q <= rd_word;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sim_mem.sv
// tb_axi_sim_mem
// Directed bench for axi_sim_mem: expected B and R responses are queued as
// stimulus is issued; a negedge monitor compares every presented response.
module tb_axi_sim_mem;
  import axi_sim_mem_pkg::*;

  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 512;
  localparam int DL = 8;
  localparam int RL = 4;
  localparam int IC = 64;
  localparam int SB = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  logic            init_calib_complete;
  logic [IW-1:0]   awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [SB-1:0]   wstrb;
  logic            wlast, wvalid, wready;
  logic [IW-1:0]   bid;
  logic [1:0]      bresp;
  logic            bvalid, bready;
  logic [IW-1:0]   arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid, arready;
  logic [IW-1:0]   rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast, rvalid, rready;

  axi_sim_mem #(
    .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .DEPTH_LOG2(DL), .RD_LATENCY(RL), .INIT_CYCLES(IC)
  ) dut (
    .clk(clk), .aresetn(aresetn), .init_calib_complete(init_calib_complete),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_rdata_q[$];
  logic [6:0]    exp_rmeta_q[$];   // {id, resp, last}
  logic [5:0]    exp_b_q[$];       // {id, resp}
  logic [DW-1:0] beat_data[16];
  logic [SB-1:0] beat_strb[16];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int n);
    return {16{n[31:0]}};
  endfunction

  task automatic push_r(input logic [IW-1:0] id, input logic [DW-1:0] d,
                        input logic [1:0] resp, input logic last);
    exp_rdata_q.push_back(d);
    exp_rmeta_q.push_back({id, resp, last});
  endtask

  always @(negedge clk) begin
    if (rvalid) begin
      if (exp_rdata_q.size() == 0) begin
        check("r_unexpected", DW'(rvalid), '0);
      end else begin
        check("rdata", rdata, exp_rdata_q[0]);
        check("rmeta", DW'({rid, rresp, rlast}), DW'(exp_rmeta_q[0]));
        if (rready) begin
          void'(exp_rdata_q.pop_front());
          void'(exp_rmeta_q.pop_front());
        end
      end
    end
    if (bvalid && bready) begin
      if (exp_b_q.size() == 0) check("b_unexpected", DW'(bvalid), '0);
      else check("bresp", DW'({bid, bresp}), DW'(exp_b_q.pop_front()));
    end
  end

  // ---------------- driver tasks (start and end at posedge + #1) ----------------
  function automatic logic rdy(input int k);
    case (k)
      0:       return awready;
      1:       return wready;
      default: return arready;
    endcase
  endfunction

  task automatic wait_rdy(input int k, input string name);
    int t = 0;
    @(negedge clk);
    while (!rdy(k) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(name, DW'(rdy(k)), DW'(1));
    @(posedge clk); #1;
  endtask

  task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd6;
    awvalid = 1'b1;
    wait_rdy(0, "aw_ready");
    awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size);
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size;
    arvalid = 1'b1;
    wait_rdy(2, "ar_ready");
    arvalid = 1'b0;
  endtask

  task automatic write_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input logic [7:0] len, input logic [1:0] burst,
                             input int wlast_beat, input logic [1:0] exp_resp);
    exp_b_q.push_back({id, exp_resp});
    aw_send(id, addr, len, burst);
    check("aw_busy", DW'(awready), '0);
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1'b1;
      wdata  = beat_data[b];
      wstrb  = beat_strb[b];
      wlast  = (b == wlast_beat);
      wait_rdy(1, "w_ready");
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    @(negedge clk);
    check("b_timing", DW'(bvalid), DW'(1));
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_rdata_q.size() != 0 || exp_b_q.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain", DW'(exp_rdata_q.size() + exp_b_q.size()), '0);
    @(posedge clk); #1;
  endtask

  task automatic wait_rvalid();
    int t = 0;
    @(negedge clk);
    while (!rvalid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rvalid_wait", DW'(rvalid), DW'(1));
  endtask

  task automatic wait_init(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == IC - 1) check("init_gate", DW'({init_calib_complete, awready, arready}), '0);
    end while (!init_calib_complete && cyc < 500);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      beat_data[i] = '0;
      beat_strb[i] = '1;
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_valid", DW'({init_calib_complete, awready, wready, bvalid, arready, rvalid, rlast}), '0);
    check("rst_payload", DW'({bid, bresp, rid, rresp}), '0);
    check("rst_rdata", rdata, '0);

    // Init counter
    @(posedge clk); #1;
    aresetn = 1'b1;
    wait_init(cyc);
    check("init_cycles", DW'(cyc), DW'(IC));

    // INCR write 0x1000, data 1..4
    for (int i = 0; i < 4; i++) beat_data[i] = pat(i + 1);
    write_burst(4'd1, 32'h1000, 8'd3, BURST_INCR, 3, RESP_OKAY);
    wait_drain();

    // INCR read back, first rvalid 5 cycles after AR
    for (int i = 0; i < 4; i++) push_r(4'd2, pat(i + 1), RESP_OKAY, i == 3);
    ar_send(4'd2, 32'h1000, 8'd3, BURST_INCR, 3'd6);
    cyc = 1;
    @(negedge clk);
    while (!rvalid && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    check("rd_latency", DW'(cyc), DW'(5));
    wait_drain();

    // WRAP read from 0x10C0: words 0x10C0, 0x1000, 0x1040, 0x1080
    push_r(4'd3, pat(4), RESP_OKAY, 1'b0);
    push_r(4'd3, pat(1), RESP_OKAY, 1'b0);
    push_r(4'd3, pat(2), RESP_OKAY, 1'b0);
    push_r(4'd3, pat(3), RESP_OKAY, 1'b1);
    ar_send(4'd3, 32'h10C0, 8'd3, BURST_WRAP, 3'd6);
    wait_drain();

    // FIXED write, complementary strobes merge into one word
    beat_data[0] = {64{8'hAA}};
    beat_strb[0] = 64'h0000_0000_FFFF_FFFF;
    beat_data[1] = {64{8'hBB}};
    beat_strb[1] = 64'hFFFF_FFFF_0000_0000;
    write_burst(4'd4, 32'h2000, 8'd1, BURST_FIXED, 1, RESP_OKAY);
    wait_drain();
    for (int i = 0; i < 16; i++) beat_strb[i] = '1;
    push_r(4'd4, {{32{8'hBB}}, {32{8'hAA}}}, RESP_OKAY, 1'b1);
    ar_send(4'd4, 32'h2000, 8'd0, BURST_INCR, 3'd6);
    wait_drain();

    // Early wlast: SLVERR after all 4 beats, data still written
    for (int i = 0; i < 4; i++) beat_data[i] = pat(i + 5);
    write_burst(4'd5, 32'h3000, 8'd3, BURST_INCR, 1, RESP_SLVERR);
    wait_drain();
    for (int i = 0; i < 4; i++) push_r(4'd5, pat(i + 5), RESP_OKAY, i == 3);
    ar_send(4'd5, 32'h3000, 8'd3, BURST_INCR, 3'd6);
    wait_drain();

    // arsize=3: SLVERR every beat, full-width data
    push_r(4'd6, pat(1), RESP_SLVERR, 1'b0);
    push_r(4'd6, pat(2), RESP_SLVERR, 1'b1);
    ar_send(4'd6, 32'h1000, 8'd1, BURST_INCR, 3'd3);
    wait_drain();

    // Reserved burst: SLVERR, advances as INCR
    push_r(4'd7, pat(1), RESP_SLVERR, 1'b0);
    push_r(4'd7, pat(2), RESP_SLVERR, 1'b1);
    ar_send(4'd7, 32'h1000, 8'd1, BURST_RSVD, 3'd6);
    wait_drain();

    // WRAP with len=2: SLVERR, advances as INCR
    for (int i = 0; i < 3; i++) push_r(4'd8, pat(i + 2), RESP_SLVERR, i == 2);
    ar_send(4'd8, 32'h1040, 8'd2, BURST_WRAP, 3'd6);
    wait_drain();

    // Same-word read and write beat in one cycle: read sees old data
    beat_data[0] = pat(9);
    write_burst(4'd9, 32'h4000, 8'd0, BURST_INCR, 0, RESP_OKAY);
    wait_drain();
    rready = 1'b0;
    push_r(4'd10, pat(9), RESP_OKAY, 1'b1);
    exp_b_q.push_back({4'd11, RESP_OKAY});
    ar_send(4'd10, 32'h4000, 8'd0, BURST_INCR, 3'd6);
    aw_send(4'd11, 32'h4000, 8'd0, BURST_INCR);
    wait_rvalid();
    @(posedge clk); #1;
    wvalid = 1'b1; wdata = pat(10); wstrb = '1; wlast = 1'b1;
    rready = 1'b1;
    @(negedge clk);
    check("collide_wready", DW'({wready, rvalid}), DW'(3));
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
    wait_drain();
    push_r(4'd12, pat(10), RESP_OKAY, 1'b1);
    ar_send(4'd12, 32'h4000, 8'd0, BURST_INCR, 3'd6);
    wait_drain();

    // rready toggling: payload held while stalled
    rready = 1'b0;
    for (int i = 0; i < 4; i++) push_r(4'd13, pat(i + 1), RESP_OKAY, i == 3);
    ar_send(4'd13, 32'h1000, 8'd3, BURST_INCR, 3'd6);
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          @(posedge clk); #1;
          rready = ~rready;
        end
      end
      wait_drain();
    join
    rready = 1'b1;

    // Reset during a stalled read: rvalid drops at once, memory kept
    rready = 1'b0;
    push_r(4'd14, pat(1), RESP_OKAY, 1'b0);
    ar_send(4'd14, 32'h1000, 8'd3, BURST_INCR, 3'd6);
    wait_rvalid();
    @(posedge clk); #1;
    aresetn = 1'b0;
    #1;
    check("rst_mid_read", DW'({rvalid, arready, init_calib_complete}), '0);
    exp_rdata_q.delete();
    exp_rmeta_q.delete();
    @(posedge clk); #1;
    aresetn = 1'b1;
    wait_init(cyc);
    check("reinit_cycles", DW'(cyc), DW'(IC));
    rready = 1'b1;
    @(negedge clk);
    check("idle_after_init", DW'({arready, awready, rvalid}), DW'(3'b110));
    @(posedge clk); #1;
    push_r(4'd15, pat(1), RESP_OKAY, 1'b1);
    ar_send(4'd15, 32'h1000, 8'd0, BURST_INCR, 3'd6);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
